// File: rtl/id_ex_stage.sv
// ID/EX pipeline register in front of the ALU.
// Latches the decoded ID fields, decodes the ALU operation, forwards operands
// from EX/MEM and MEM/WB, and generates the load-use stall for ID.
//
// Handshake: ID offers an instruction with id_valid. It is taken on a rising
// edge only when id_ready is high. id_ready is ex_ready & !load_use & !flush.
// ex_ready low freezes this stage. Flush discards both the ID offer and the
// current EX contents.
module id_ex_stage #(
  parameter int SIZEDATA = 32,
  parameter int OP       = 4,
  parameter int REGADDR  = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                id_valid,
  output logic                id_ready,
  input  logic [SIZEDATA-1:0] id_rs_data,
  input  logic [SIZEDATA-1:0] id_rt_data,
  input  logic [SIZEDATA-1:0] id_imm,
  input  logic [REGADDR-1:0]  id_rs,
  input  logic [REGADDR-1:0]  id_rt,
  input  logic [REGADDR-1:0]  id_rd,
  input  logic [1:0]          id_aluop,
  input  logic [5:0]          id_funct,
  input  logic                id_alusrc,
  input  logic                id_regdst,
  input  logic                id_regwrite,
  input  logic                id_memread,
  input  logic                id_memwrite,
  input  logic                id_memtoreg,
  input  logic                flush,
  input  logic                ex_ready,
  input  logic                exm_regwrite,
  input  logic [REGADDR-1:0]  exm_rd,
  input  logic [SIZEDATA-1:0] exm_result,
  input  logic                wb_regwrite,
  input  logic [REGADDR-1:0]  wb_rd,
  input  logic [SIZEDATA-1:0] wb_data,
  output logic [SIZEDATA-1:0] a,
  output logic [SIZEDATA-1:0] b,
  output logic [OP-1:0]       operador,
  output logic                ex_valid,
  output logic [REGADDR-1:0]  ex_wdest,
  output logic [SIZEDATA-1:0] ex_store_data,
  output logic                ex_regwrite,
  output logic                ex_memread,
  output logic                ex_memwrite,
  output logic                ex_memtoreg,
  output logic                ex_illegal
);

  localparam logic [OP-1:0] OP_AND = 4'b0000;
  localparam logic [OP-1:0] OP_OR  = 4'b0001;
  localparam logic [OP-1:0] OP_ADD = 4'b0010;
  localparam logic [OP-1:0] OP_SUB = 4'b0110;
  localparam logic [OP-1:0] OP_SLT = 4'b0111;
  localparam logic [OP-1:0] OP_NOR = 4'b1100;

  logic                valid_q, valid_d;
  logic [REGADDR-1:0]  rs_idx_q, rs_idx_d;
  logic [REGADDR-1:0]  rt_idx_q, rt_idx_d;
  logic [SIZEDATA-1:0] rs_val_q, rs_val_d;
  logic [SIZEDATA-1:0] rt_val_q, rt_val_d;
  logic [SIZEDATA-1:0] imm_q, imm_d;
  logic                alusrc_q, alusrc_d;
  logic [REGADDR-1:0]  wdest_q, wdest_d;
  logic                regwrite_q, regwrite_d;
  logic                memread_q, memread_d;
  logic                memwrite_q, memwrite_d;
  logic                memtoreg_q, memtoreg_d;
  logic [OP-1:0]       op_q, op_d;
  logic                illegal_q, illegal_d;

  logic [SIZEDATA-1:0] fwd_rs, fwd_rt;
  logic [OP-1:0]       dec_op;
  logic                dec_illegal;
  logic                load_use;

  // Operand forwarding on the latched indices; EX/MEM is the younger producer and wins. $0 never forwards.
  always_comb begin
    fwd_rs = rs_val_q;
    fwd_rt = rt_val_q;
    if (exm_regwrite && exm_rd != '0 && exm_rd == rs_idx_q)
      fwd_rs = exm_result;
    else if (wb_regwrite && wb_rd != '0 && wb_rd == rs_idx_q)
      fwd_rs = wb_data;
    if (exm_regwrite && exm_rd != '0 && exm_rd == rt_idx_q)
      fwd_rt = exm_result;
    else if (wb_regwrite && wb_rd != '0 && wb_rd == rt_idx_q)
      fwd_rt = wb_data;
  end

  // ALU control decode of the instruction currently offered by ID.
  always_comb begin
    dec_op      = OP_ADD;
    dec_illegal = 1'b0;
    unique case (id_aluop)
      2'b00: dec_op = OP_ADD;
      2'b01: dec_op = OP_SUB;
      2'b11: dec_op = OP_OR;
      default: begin
        case (id_funct)
          6'b100000, 6'b100001: dec_op = OP_ADD;
          6'b100010, 6'b100011: dec_op = OP_SUB;
          6'b100100:            dec_op = OP_AND;
          6'b100101:            dec_op = OP_OR;
          6'b100111:            dec_op = OP_NOR;
          6'b101010:            dec_op = OP_SLT;
          default: begin
            dec_op      = OP_ADD;
            dec_illegal = 1'b1;
          end
        endcase
      end
    endcase
  end

  // Load-use hazard: the load in EX cannot forward in time to an ID reader of its destination.
  always_comb begin
    load_use = valid_q && memread_q && (wdest_q != '0) && id_valid &&
               ((id_rs == wdest_q) ||
                ((!id_alusrc || id_memwrite) && (id_rt == wdest_q)));
    id_ready = ex_ready && !load_use && !flush;
  end

  // Next-state selection: flush, then hold, then bubble, then load from ID.
  always_comb begin
    valid_d    = valid_q;
    rs_idx_d   = rs_idx_q;
    rt_idx_d   = rt_idx_q;
    rs_val_d   = rs_val_q;
    rt_val_d   = rt_val_q;
    imm_d      = imm_q;
    alusrc_d   = alusrc_q;
    wdest_d    = wdest_q;
    regwrite_d = regwrite_q;
    memread_d  = memread_q;
    memwrite_d = memwrite_q;
    memtoreg_d = memtoreg_q;
    op_d       = op_q;
    illegal_d  = illegal_q;
    if (flush) begin
      valid_d    = 1'b0;
      regwrite_d = 1'b0;
      memread_d  = 1'b0;
      memwrite_d = 1'b0;
      memtoreg_d = 1'b0;
      illegal_d  = 1'b0;
    end else if (!ex_ready) begin
      // Capture any producer retiring during the hold so the value is not lost.
      rs_val_d = fwd_rs;
      rt_val_d = fwd_rt;
    end else if (load_use) begin
      valid_d    = 1'b0;
      regwrite_d = 1'b0;
      memread_d  = 1'b0;
      memwrite_d = 1'b0;
    end else begin
      valid_d    = id_valid;
      rs_idx_d   = id_rs;
      rt_idx_d   = id_rt;
      rs_val_d   = id_rs_data;
      rt_val_d   = id_rt_data;
      imm_d      = id_imm;
      alusrc_d   = id_alusrc;
      wdest_d    = id_regdst ? id_rd : id_rt;
      regwrite_d = id_valid && id_regwrite && !dec_illegal;
      memread_d  = id_valid && id_memread;
      memwrite_d = id_valid && id_memwrite;
      memtoreg_d = id_valid && id_memtoreg;
      op_d       = dec_op;
      illegal_d  = id_valid && dec_illegal;
    end
  end

  // Pipeline register bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      rs_idx_q   <= '0;
      rt_idx_q   <= '0;
      rs_val_q   <= '0;
      rt_val_q   <= '0;
      imm_q      <= '0;
      alusrc_q   <= 1'b0;
      wdest_q    <= '0;
      regwrite_q <= 1'b0;
      memread_q  <= 1'b0;
      memwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
      op_q       <= '0;
      illegal_q  <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      rs_idx_q   <= rs_idx_d;
      rt_idx_q   <= rt_idx_d;
      rs_val_q   <= rs_val_d;
      rt_val_q   <= rt_val_d;
      imm_q      <= imm_d;
      alusrc_q   <= alusrc_d;
      wdest_q    <= wdest_d;
      regwrite_q <= regwrite_d;
      memread_q  <= memread_d;
      memwrite_q <= memwrite_d;
      memtoreg_q <= memtoreg_d;
      op_q       <= op_d;
      illegal_q  <= illegal_d;
    end
  end

  // Output drive.
  always_comb begin
    a             = fwd_rs;
    b             = alusrc_q ? imm_q : fwd_rt;
    ex_store_data = fwd_rt;
    operador      = op_q;
    ex_valid      = valid_q;
    ex_wdest      = wdest_q;
    ex_regwrite   = regwrite_q;
    ex_memread    = memread_q;
    ex_memwrite   = memwrite_q;
    ex_memtoreg   = memtoreg_q;
    ex_illegal    = illegal_q;
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Testbench for id_ex_stage: directed scenarios followed by random traffic,
// all checked against a reference model of the EX-stage contents.
module tb_id_ex_stage;

  logic        clk, rst_n;
  logic        id_valid, id_ready;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [1:0]  id_aluop;
  logic [5:0]  id_funct;
  logic        id_alusrc, id_regdst, id_regwrite, id_memread, id_memwrite, id_memtoreg;
  logic        flush, ex_ready;
  logic        exm_regwrite, wb_regwrite;
  logic [4:0]  exm_rd, wb_rd;
  logic [31:0] exm_result, wb_data;
  logic [31:0] a, b, ex_store_data;
  logic [3:0]  operador;
  logic        ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_illegal;
  logic [4:0]  ex_wdest;

  int checks = 0;
  int failures = 0;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ready(id_ready),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_aluop(id_aluop), .id_funct(id_funct),
    .id_alusrc(id_alusrc), .id_regdst(id_regdst), .id_regwrite(id_regwrite),
    .id_memread(id_memread), .id_memwrite(id_memwrite), .id_memtoreg(id_memtoreg),
    .flush(flush), .ex_ready(ex_ready),
    .exm_regwrite(exm_regwrite), .exm_rd(exm_rd), .exm_result(exm_result),
    .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data),
    .a(a), .b(b), .operador(operador), .ex_valid(ex_valid), .ex_wdest(ex_wdest),
    .ex_store_data(ex_store_data), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .ex_memwrite(ex_memwrite), .ex_memtoreg(ex_memtoreg), .ex_illegal(ex_illegal)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: what the EX stage is holding
  typedef struct {
    bit          v;
    logic [4:0]  rs, rt, wdest;
    logic [31:0] rsv, rtv, imm;
    bit          alusrc, rw, mr, mw, mtr, ill;
    logic [3:0]  op;
  } ex_t;
  ex_t m;

  function automatic ex_t zero_model();
    ex_t z;
    z.v = 0; z.rs = 0; z.rt = 0; z.wdest = 0; z.rsv = 0; z.rtv = 0; z.imm = 0;
    z.alusrc = 0; z.rw = 0; z.mr = 0; z.mw = 0; z.mtr = 0; z.ill = 0; z.op = 0;
    return z;
  endfunction

  // ALU operation expected for an aluop/funct pair; ill set for unsupported functs
  function automatic logic [3:0] ref_op(input logic [1:0] aluop, input logic [5:0] funct, output bit ill);
    ill = 0;
    if (aluop == 2'b00) return 4'b0010;
    if (aluop == 2'b01) return 4'b0110;
    if (aluop == 2'b11) return 4'b0001;
    if (funct == 6'd32 || funct == 6'd33) return 4'b0010;
    if (funct == 6'd34 || funct == 6'd35) return 4'b0110;
    if (funct == 6'd36) return 4'b0000;
    if (funct == 6'd37) return 4'b0001;
    if (funct == 6'd39) return 4'b1100;
    if (funct == 6'd42) return 4'b0111;
    ill = 1;
    return 4'b0010;
  endfunction

  // Most recent producer of register idx, or the held value
  function automatic logic [31:0] ref_fwd(input logic [4:0] idx, input logic [31:0] held);
    if (idx == 0) return held;
    if (exm_regwrite && exm_rd == idx) return exm_result;
    if (wb_regwrite && wb_rd == idx) return wb_data;
    return held;
  endfunction

  function automatic bit ref_load_use();
    if (!(m.v && m.mr && m.wdest != 0 && id_valid)) return 0;
    if (id_rs == m.wdest) return 1;
    return (!id_alusrc || id_memwrite) && id_rt == m.wdest;
  endfunction

  function automatic ex_t ref_next();
    ex_t n = m;
    bit ill;
    logic [3:0] op;
    if (flush) begin
      n.v = 0; n.rw = 0; n.mr = 0; n.mw = 0; n.mtr = 0; n.ill = 0;
    end else if (!ex_ready) begin
      n.rsv = ref_fwd(m.rs, m.rsv);
      n.rtv = ref_fwd(m.rt, m.rtv);
    end else if (ref_load_use()) begin
      n.v = 0; n.rw = 0; n.mr = 0; n.mw = 0;
    end else begin
      op = ref_op(id_aluop, id_funct, ill);
      n.v = id_valid; n.rs = id_rs; n.rt = id_rt;
      n.rsv = id_rs_data; n.rtv = id_rt_data; n.imm = id_imm; n.alusrc = id_alusrc;
      n.wdest = id_regdst ? id_rd : id_rt;
      n.rw = id_valid && id_regwrite && !ill;
      n.mr = id_valid && id_memread;
      n.mw = id_valid && id_memwrite;
      n.mtr = id_valid && id_memtoreg;
      n.op = op;
      n.ill = id_valid && ill;
    end
    return n;
  endfunction

  // Scoreboard comparison
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic chk_comb();
    chk("id_ready", {31'd0, id_ready}, {31'd0, ex_ready && !ref_load_use() && !flush});
    chk("a", a, ref_fwd(m.rs, m.rsv));
    chk("store_data", ex_store_data, ref_fwd(m.rt, m.rtv));
    chk("b", b, m.alusrc ? m.imm : ref_fwd(m.rt, m.rtv));
  endtask

  task automatic chk_regs();
    chk("ex_valid", {31'd0, ex_valid}, {31'd0, m.v});
    chk("operador", {28'd0, operador}, {28'd0, m.op});
    chk("ex_wdest", {27'd0, ex_wdest}, {27'd0, m.wdest});
    chk("ex_ctrl", {27'd0, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_illegal},
        {27'd0, m.rw, m.mr, m.mw, m.mtr, m.ill});
  endtask

  // Driver: inputs are already applied at the falling edge; check, clock once, check again
  task automatic step();
    ex_t n;
    #1;
    chk_comb();
    n = ref_next();
    @(posedge clk);
    m = n;
    @(negedge clk);
    chk_regs();
  endtask

  task automatic idle_inputs();
    id_valid = 0; id_rs_data = 0; id_rt_data = 0; id_imm = 0;
    id_rs = 0; id_rt = 0; id_rd = 0; id_aluop = 0; id_funct = 0;
    id_alusrc = 0; id_regdst = 0; id_regwrite = 0; id_memread = 0; id_memwrite = 0; id_memtoreg = 0;
    flush = 0; ex_ready = 1;
    exm_regwrite = 0; exm_rd = 0; exm_result = 0;
    wb_regwrite = 0; wb_rd = 0; wb_data = 0;
  endtask

  task automatic set_rtype(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                           input logic [31:0] rsv, input logic [31:0] rtv, input logic [5:0] funct);
    id_valid = 1; id_rs = rs; id_rt = rt; id_rd = rd; id_rs_data = rsv; id_rt_data = rtv;
    id_imm = 32'hFFFF_FFF0; id_aluop = 2'b10; id_funct = funct;
    id_alusrc = 0; id_regdst = 1; id_regwrite = 1; id_memread = 0; id_memwrite = 0; id_memtoreg = 0;
  endtask

  initial begin
    logic [5:0] functs[10];
    functs = '{6'd32, 6'd33, 6'd34, 6'd35, 6'd36, 6'd37, 6'd39, 6'd42, 6'd7, 6'd0};
    m = zero_model();
    idle_inputs();
    rst_n = 0;
    repeat (2) @(negedge clk);
    chk("reset_valid", {31'd0, ex_valid}, 32'd0);
    chk("reset_op", {28'd0, operador}, 32'd0);
    chk("reset_a", a, 32'd0);
    chk("reset_b", b, 32'd0);
    rst_n = 1;

    // ADD r3,r1,r2
    set_rtype(5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 6'b100000);
    step();
    chk("add_a", a, 32'd5);
    chk("add_b", b, 32'd7);
    chk("add_op", {28'd0, operador}, 32'b0010);
    chk("add_wdest", {27'd0, ex_wdest}, 32'd3);

    // EX/MEM beats MEM/WB on rs=1; then $0 never forwards
    idle_inputs();
    exm_regwrite = 1; exm_rd = 1; exm_result = 99;
    wb_regwrite = 1; wb_rd = 1; wb_data = 11;
    #1;
    chk("fwd_exm_priority", a, 32'd99);
    set_rtype(5'd0, 5'd2, 5'd3, 32'd42, 32'd7, 6'b100000);
    step();
    exm_rd = 0; wb_rd = 0;
    #1;
    chk("fwd_r0", a, 32'd42);
    @(negedge clk);

    // LW r4 then ADD r5,r4,r4
    idle_inputs();
    id_valid = 1; id_rs = 2; id_rt = 4; id_imm = 8; id_aluop = 0;
    id_alusrc = 1; id_regdst = 0; id_regwrite = 1; id_memread = 1; id_memtoreg = 1;
    step();
    set_rtype(5'd4, 5'd4, 5'd5, 32'd0, 32'd0, 6'b100000);
    #1;
    chk("lu_ready", {31'd0, id_ready}, 32'd0);
    step();
    chk("lu_bubble", {31'd0, ex_valid}, 32'd0);
    exm_regwrite = 1; exm_rd = 4; exm_result = 32'hABCD;
    step();
    chk("lu_valid", {31'd0, ex_valid}, 32'd1);
    chk("lu_a", a, 32'hABCD);
    chk("lu_b", b, 32'hABCD);

    // Backpressure while MEM/WB retires rt=6
    idle_inputs();
    set_rtype(5'd2, 5'd6, 5'd7, 32'd3, 32'd0, 6'b100101);
    step();
    ex_ready = 0;
    wb_regwrite = 1; wb_rd = 6; wb_data = 32'h1234;
    step();
    wb_regwrite = 0;
    step();
    step();
    chk("hold_b", b, 32'h1234);
    chk("hold_op", {28'd0, operador}, 32'b0001);
    chk("hold_wdest", {27'd0, ex_wdest}, 32'd7);

    // Flush, then an unsupported funct
    idle_inputs();
    set_rtype(5'd1, 5'd2, 5'd3, 32'd1, 32'd2, 6'b100000);
    flush = 1;
    step();
    chk("flush_valid", {31'd0, ex_valid}, 32'd0);
    chk("flush_rw", {31'd0, ex_regwrite}, 32'd0);
    flush = 0;
    id_funct = 6'b000111;
    step();
    chk("illegal", {31'd0, ex_illegal}, 32'd1);
    chk("illegal_rw", {31'd0, ex_regwrite}, 32'd0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      id_valid = ($urandom_range(0, 9) < 8);
      id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3)); id_rd = 5'($urandom_range(0, 3));
      id_rs_data = $urandom; id_rt_data = $urandom; id_imm = $urandom;
      id_aluop = 2'($urandom_range(0, 3)); id_funct = functs[$urandom_range(0, 9)];
      id_alusrc = 1'($urandom_range(0, 1)); id_regdst = 1'($urandom_range(0, 1));
      id_regwrite = 1'($urandom_range(0, 1)); id_memread = 1'($urandom_range(0, 1));
      id_memwrite = 1'($urandom_range(0, 1)); id_memtoreg = 1'($urandom_range(0, 1));
      flush = ($urandom_range(0, 9) == 0);
      ex_ready = ($urandom_range(0, 9) < 8);
      exm_regwrite = 1'($urandom_range(0, 1)); exm_rd = 5'($urandom_range(0, 3)); exm_result = $urandom;
      wb_regwrite = 1'($urandom_range(0, 1)); wb_rd = 5'($urandom_range(0, 3)); wb_data = $urandom;
      step();
    end

    // Asynchronous reset mid-stream
    set_rtype(5'd1, 5'd2, 5'd3, 32'd1, 32'd2, 6'b100010);
    exm_regwrite = 0; wb_regwrite = 0; flush = 0; ex_ready = 1;
    step();
    #2;
    rst_n = 0;
    #1;
    chk("async_valid", {31'd0, ex_valid}, 32'd0);
    chk("async_op", {28'd0, operador}, 32'd0);
    chk("async_a", a, 32'd0);
    m = zero_model();
    @(negedge clk);
    rst_n = 1;
    idle_inputs();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
